// File: rtl/nonce_search_ctrl.sv
// nonce_search_ctrl
//   Drives the concatenator + micro_hash pair through a nonce search. Starting
//   at nonce_init, it launches one hash per nonce. Each result's top byte is
//   compared against the target byte sampled at start. The search stops on the
//   first hit, after nonce_limit (inclusive, with wrap-around), on abort, or
//   when the hash watchdog expires.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   start        one-cycle start pulse, honoured only in IDLE without abort
//   abort        level; ends an active search with no flag set
//   nonce_init   first nonce to try
//   nonce_limit  last nonce to try (inclusive)
//   target       difficulty byte; hit when hash top byte < target
//   hash_done    one-cycle completion pulse from micro_hash
//   hash_in      hash result, valid while hash_done is high
//   hash_start   one-cycle launch pulse to micro_hash
//   nonce_out    current nonce; stable from hash_start until the check ends
//   busy         high whenever the FSM is not IDLE
//   found        sticky: last search ended on a hit
//   exhausted    sticky: last search reached the limit with no hit
//   timeout_err  sticky: watchdog expired waiting for hash_done
//   nonce_found  nonce of the most recent hit
//   hash_found   hash of the most recent hit
//   attempts     hashes completed in the current or last search (modular)
//   dbg_state    current FSM state (0 IDLE, 1 LAUNCH, 2 WAIT, 3 CHECK)
//
// Handshake: hash_start and hash_done are single-cycle pulses. Exactly one
// hash_done is accepted per hash_start, and only while in WAIT. A hash_done
// in any other state is dropped.

module nonce_search_ctrl #(
  parameter int NONCE_W   = 32,
  parameter int HASH_W    = 24,
  parameter int TIMEOUT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [NONCE_W-1:0] nonce_init,
  input  logic [NONCE_W-1:0] nonce_limit,
  input  logic [7:0]         target,
  input  logic               hash_done,
  input  logic [HASH_W-1:0]  hash_in,
  output logic               hash_start,
  output logic [NONCE_W-1:0] nonce_out,
  output logic               busy,
  output logic               found,
  output logic               exhausted,
  output logic               timeout_err,
  output logic [NONCE_W-1:0] nonce_found,
  output logic [HASH_W-1:0]  hash_found,
  output logic [NONCE_W-1:0] attempts,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_CHECK  = 2'd3
  } state_e;

  // The watchdog holds the number of WAIT cycles already spent. Expiry fires
  // in the WAIT cycle that brings the total to 2**TIMEOUT_W-1.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {TIMEOUT_W{1'b1}} - 1'b1;

  state_e               state_q, state_d;
  logic [NONCE_W-1:0]   nonce_q, nonce_d;
  logic [NONCE_W-1:0]   limit_q, limit_d;
  logic [7:0]           target_q, target_d;
  logic [HASH_W-1:0]    hash_q, hash_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic [NONCE_W-1:0]   attempts_q, attempts_d;
  logic                 found_q, found_d;
  logic                 exh_q, exh_d;
  logic                 to_q, to_d;
  logic [NONCE_W-1:0]   nonce_found_q, nonce_found_d;
  logic [HASH_W-1:0]    hash_found_q, hash_found_d;
  logic                 hit;

  assign hit = (hash_q[HASH_W-1 -: 8] < target_q);

  always_comb begin
    state_d       = state_q;
    nonce_d       = nonce_q;
    limit_d       = limit_q;
    target_d      = target_q;
    hash_d        = hash_q;
    wd_d          = wd_q;
    attempts_d    = attempts_q;
    found_d       = found_q;
    exh_d         = exh_q;
    to_d          = to_q;
    nonce_found_d = nonce_found_q;
    hash_found_d  = hash_found_q;

    case (state_q)
      S_IDLE: begin
        // start together with abort is dropped.
        if (start && !abort) begin
          target_d   = target;
          limit_d    = nonce_limit;
          nonce_d    = nonce_init;
          found_d    = 1'b0;
          exh_d      = 1'b0;
          to_d       = 1'b0;
          attempts_d = '0;
          state_d    = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          wd_d    = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Priority: abort, then hash_done, then watchdog expiry.
        if (abort) begin
          state_d = S_IDLE;
        end else if (hash_done) begin
          hash_d     = hash_in;
          attempts_d = attempts_q + 1'b1;
          state_d    = S_CHECK;
        end else if (wd_q == WD_LAST) begin
          to_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (hit) begin
          found_d       = 1'b1;
          nonce_found_d = nonce_q;
          hash_found_d  = hash_q;
          state_d       = S_IDLE;
        end else if (nonce_q == limit_q) begin
          exh_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          // Wraps naturally through all-ones to zero.
          nonce_d = nonce_q + 1'b1;
          state_d = S_LAUNCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      nonce_q       <= '0;
      limit_q       <= '0;
      target_q      <= '0;
      hash_q        <= '0;
      wd_q          <= '0;
      attempts_q    <= '0;
      found_q       <= 1'b0;
      exh_q         <= 1'b0;
      to_q          <= 1'b0;
      nonce_found_q <= '0;
      hash_found_q  <= '0;
    end else begin
      state_q       <= state_d;
      nonce_q       <= nonce_d;
      limit_q       <= limit_d;
      target_q      <= target_d;
      hash_q        <= hash_d;
      wd_q          <= wd_d;
      attempts_q    <= attempts_d;
      found_q       <= found_d;
      exh_q         <= exh_d;
      to_q          <= to_d;
      nonce_found_q <= nonce_found_d;
      hash_found_q  <= hash_found_d;
    end
  end

  // hash_start is decoded from the state register so that an abort arriving
  // during LAUNCH can still suppress the launch in that same cycle.
  assign hash_start  = (state_q == S_LAUNCH) && !abort;
  assign busy        = (state_q != S_IDLE);
  assign nonce_out   = nonce_q;
  assign found       = found_q;
  assign exhausted   = exh_q;
  assign timeout_err = to_q;
  assign nonce_found = nonce_found_q;
  assign hash_found  = hash_found_q;
  assign attempts    = attempts_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Directed bench for nonce_search_ctrl. A behavioural micro_hash answers each
// hash_start after LAT cycles. The hash top byte comes from model_mode, and
// the low 16 bits carry the nonce.

module tb_nonce_search_ctrl;

  localparam int NW  = 32;
  localparam int HW  = 24;
  localparam int TW  = 4;
  localparam int LAT = 2;

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [NW-1:0] nonce_init;
  logic [NW-1:0] nonce_limit;
  logic [7:0]    target;
  logic          hash_done;
  logic [HW-1:0] hash_in;
  logic          hash_start;
  logic [NW-1:0] nonce_out;
  logic          busy;
  logic          found;
  logic          exhausted;
  logic          timeout_err;
  logic [NW-1:0] nonce_found;
  logic [HW-1:0] hash_found;
  logic [NW-1:0] attempts;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  nonce_search_ctrl #(.NONCE_W(NW), .HASH_W(HW), .TIMEOUT_W(TW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .nonce_init(nonce_init), .nonce_limit(nonce_limit), .target(target),
    .hash_done(hash_done), .hash_in(hash_in), .hash_start(hash_start),
    .nonce_out(nonce_out), .busy(busy), .found(found), .exhausted(exhausted),
    .timeout_err(timeout_err), .nonce_found(nonce_found),
    .hash_found(hash_found), .attempts(attempts), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- hash model ----------------
  // mode 0: top byte 0x10; mode 1: top byte 0x00 only for nonce 0, else 0xFF;
  // mode 2: never answers.
  int            model_mode = 0;
  logic          model_done = 1'b0;
  logic [HW-1:0] model_hash = '0;
  logic          stray_done = 1'b0;
  logic [NW-1:0] model_nonce;
  logic [NW-1:0] seen_q[$];
  logic [NW-1:0] exp_q[$];
  int            starts_seen = 0;

  assign hash_done = model_done | stray_done;
  assign hash_in   = stray_done ? 24'h000000 : model_hash;

  function automatic logic [7:0] model_top(input logic [NW-1:0] n);
    if (model_mode == 1) return (n == 0) ? 8'h00 : 8'hFF;
    return 8'h10;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (hash_start === 1'b1) begin
        seen_q.push_back(nonce_out);
        starts_seen++;
        if (model_mode != 2) begin
          model_nonce = nonce_out;
          repeat (LAT - 1) @(posedge clk);
          #1;
          model_done = 1'b1;
          model_hash = {model_top(model_nonce), model_nonce[15:0]};
          @(posedge clk);
          #1 model_done = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [NW-1:0] init, input logic [NW-1:0] lim,
                          input logic [7:0] tgt);
    @(negedge clk);
    nonce_init  = init;
    nonce_limit = lim;
    target      = tgt;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the first negedge with busy low; ok=0 if max cycles elapse.
  task automatic wait_idle(input int max, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < max; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, found, exhausted, timeout_err, hash_start} !== 5'b0) begin
      n_fail++; $display("FAIL reset.flags got=%b exp=00000",
                         {busy, found, exhausted, timeout_err, hash_start});
    end
    n_checks++;
    if ({nonce_out, nonce_found, hash_found, attempts} !== '0) begin
      n_fail++; $display("FAIL reset.values got nonce_out=%h nonce_found=%h hash_found=%h attempts=%0d exp all 0",
                         nonce_out, nonce_found, hash_found, attempts);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_hit();
    bit ok; int cyc;
    model_mode = 0;
    seen_q.delete();
    do_start(32'h3c87edfd, 32'h3c87ee01, 8'hff);
    n_checks++;
    if (hash_start !== 1'b1) begin
      n_fail++; $display("FAIL first_hit.launch_latency hash_start got=%b exp=1", hash_start);
    end
    wait_idle(40, ok, cyc);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL first_hit.done got=timeout exp=idle"); end
    n_checks++;
    if (cyc != LAT + 2) begin
      n_fail++; $display("FAIL first_hit.cycles got=%0d exp=%0d", cyc, LAT + 2);
    end
    n_checks++;
    if ({found, exhausted, timeout_err} !== 3'b100) begin
      n_fail++; $display("FAIL first_hit.flags got=%b exp=100", {found, exhausted, timeout_err});
    end
    n_checks++;
    if (nonce_found !== 32'h3c87edfd) begin
      n_fail++; $display("FAIL first_hit.nonce_found got=%h exp=3c87edfd", nonce_found);
    end
    n_checks++;
    if (hash_found !== 24'h10edfd) begin
      n_fail++; $display("FAIL first_hit.hash_found got=%h exp=10edfd", hash_found);
    end
    n_checks++;
    if (attempts !== 32'd1) begin
      n_fail++; $display("FAIL first_hit.attempts got=%0d exp=1", attempts);
    end
  endtask

  task automatic test_abort_hit();
    bit ok; bit seen_done; int cyc;
    model_mode = 0;
    do_start(32'h100, 32'h104, 8'hff);
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (hash_done === 1'b1) begin seen_done = 1'b1; break; end
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if (seen_done !== 1'b1) begin n_fail++; $display("FAIL abort_hit.hash_done got=never exp=pulse"); end
    n_checks++;
    if ({busy, found, exhausted, timeout_err} !== 4'b0000) begin
      n_fail++; $display("FAIL abort_hit.flags got=%b exp=0000", {busy, found, exhausted, timeout_err});
    end
    n_checks++;
    if (nonce_found !== 32'h3c87edfd || hash_found !== 24'h10edfd) begin
      n_fail++; $display("FAIL abort_hit.kept got=%h/%h exp=3c87edfd/10edfd", nonce_found, hash_found);
    end
    n_checks++;
    if (attempts !== 32'd0) begin
      n_fail++; $display("FAIL abort_hit.attempts got=%0d exp=0", attempts);
    end
    do_start(32'h200, 32'h200, 8'hff);
    wait_idle(40, ok, cyc);
    n_checks++;
    if (ok !== 1'b1 || found !== 1'b1 || nonce_found !== 32'h200 || attempts !== 32'd1) begin
      n_fail++; $display("FAIL abort_hit.restart got ok=%b found=%b nonce_found=%h attempts=%0d exp 1/1/200/1",
                         ok, found, nonce_found, attempts);
    end
  endtask

  task automatic test_exhaust();
    bit ok; int cyc; logic [NW-1:0] e; logic [NW-1:0] s;
    model_mode = 0;
    seen_q.delete();
    exp_q = {32'd5, 32'd6, 32'd7};
    do_start(32'd5, 32'd7, 8'h00);
    // A start pulse while busy, with a target that would hit, must be ignored.
    do_start(32'd100, 32'd100, 8'hff);
    wait_idle(60, ok, cyc);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL exhaust.done got=timeout exp=idle"); end
    n_checks++;
    if ({found, exhausted, timeout_err} !== 3'b010) begin
      n_fail++; $display("FAIL exhaust.flags got=%b exp=010", {found, exhausted, timeout_err});
    end
    n_checks++;
    if (attempts !== 32'd3) begin n_fail++; $display("FAIL exhaust.attempts got=%0d exp=3", attempts); end
    n_checks++;
    if (seen_q.size() != 3) begin
      n_fail++; $display("FAIL exhaust.pulses got=%0d exp=3", seen_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      s = (seen_q.size() > 0) ? seen_q.pop_front() : 32'hxxxxxxxx;
      n_checks++;
      if (s !== e) begin n_fail++; $display("FAIL exhaust.nonce got=%h exp=%h", s, e); end
    end
  endtask

  task automatic test_wrap();
    bit ok; int cyc; logic [NW-1:0] e; logic [NW-1:0] s;
    model_mode = 1;
    seen_q.delete();
    exp_q = {32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0};
    do_start(32'hFFFFFFFE, 32'h1, 8'h01);
    wait_idle(60, ok, cyc);
    n_checks++;
    if (ok !== 1'b1 || {found, exhausted, timeout_err} !== 3'b100) begin
      n_fail++; $display("FAIL wrap.flags got ok=%b fet=%b exp 1/100", ok, {found, exhausted, timeout_err});
    end
    n_checks++;
    if (nonce_found !== 32'h0 || hash_found !== 24'h0 || attempts !== 32'd3) begin
      n_fail++; $display("FAIL wrap.result got nonce_found=%h hash_found=%h attempts=%0d exp 0/0/3",
                         nonce_found, hash_found, attempts);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      s = (seen_q.size() > 0) ? seen_q.pop_front() : 32'hxxxxxxxx;
      n_checks++;
      if (s !== e) begin n_fail++; $display("FAIL wrap.nonce got=%h exp=%h", s, e); end
    end
  endtask

  task automatic test_target_strict();
    bit ok; int cyc;
    model_mode = 0;
    // Top byte equal to target is not a hit; init==limit gives one attempt.
    do_start(32'd9, 32'd9, 8'h10);
    wait_idle(40, ok, cyc);
    n_checks++;
    if (ok !== 1'b1 || {found, exhausted} !== 2'b01 || attempts !== 32'd1) begin
      n_fail++; $display("FAIL strict.equal got ok=%b fe=%b attempts=%0d exp 1/01/1",
                         ok, {found, exhausted}, attempts);
    end
    do_start(32'd9, 32'd9, 8'h11);
    wait_idle(40, ok, cyc);
    n_checks++;
    if (ok !== 1'b1 || found !== 1'b1 || nonce_found !== 32'd9 || hash_found !== 24'h100009) begin
      n_fail++; $display("FAIL strict.above got ok=%b found=%b nonce_found=%h hash_found=%h exp 1/1/9/100009",
                         ok, found, nonce_found, hash_found);
    end
  endtask

  task automatic test_stray();
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || attempts !== 32'd1 || found !== 1'b1) begin
      n_fail++; $display("FAIL stray got busy=%b attempts=%0d found=%b exp 0/1/1", busy, attempts, found);
    end
  endtask

  task automatic test_timeout();
    model_mode = 2;
    do_start(32'h40, 32'h50, 8'hff);
    repeat (15) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL timeout.early got busy=%b timeout_err=%b exp 1/0", busy, timeout_err);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || {found, exhausted, timeout_err} !== 3'b001) begin
      n_fail++; $display("FAIL timeout.expire got busy=%b fet=%b exp 0/001", busy, {found, exhausted, timeout_err});
    end
    n_checks++;
    if (attempts !== 32'd0) begin n_fail++; $display("FAIL timeout.attempts got=%0d exp=0", attempts); end
  endtask

  task automatic test_start_abort();
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || timeout_err !== 1'b1) begin
      n_fail++; $display("FAIL start_abort got busy=%b timeout_err=%b exp 0/1", busy, timeout_err);
    end
  endtask

  task automatic test_reset_mid_wait();
    int starts_before;
    model_mode = 2;
    do_start(32'h55, 32'h60, 8'hff);
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || nonce_out !== 32'h55) begin
      n_fail++; $display("FAIL reset_mid.pre got busy=%b nonce_out=%h exp 1/55", busy, nonce_out);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({busy, found, exhausted, timeout_err, hash_start} !== 5'b0 ||
        {nonce_out, nonce_found, hash_found, attempts} !== '0) begin
      n_fail++; $display("FAIL reset_mid.async got flags=%b nonce_out=%h nonce_found=%h hash_found=%h exp all 0",
                         {busy, found, exhausted, timeout_err, hash_start}, nonce_out, nonce_found, hash_found);
    end
    @(negedge clk);
    reset = 1'b1;
    starts_before = starts_seen;
    repeat (6) @(negedge clk);
    n_checks++;
    if (starts_seen != starts_before || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid.quiet got starts=%0d busy=%b exp %0d/0", starts_seen, busy, starts_before);
    end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    nonce_init = '0; nonce_limit = '0; target = '0;
    test_reset();
    test_first_hit();
    test_abort_hit();
    test_exhaust();
    test_wrap();
    test_target_strict();
    test_stray();
    test_timeout();
    test_start_abort();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=stuck exp=finished");
    $fatal(1, "bench timed out");
  end

endmodule
